// File: rtl/wb_dma_grant_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_dma_grant_pkg
// Brief    : Shared types and constants for the DMA channel grant sequencer.
// Revision : 1.0
// ============================================================================
package wb_dma_grant_pkg;

    localparam int CH_IDX_W     = 5;
    localparam int CH_COUNT_MAX = 31;
    localparam int PRI_W_DEF    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2,
        BUSY  = 2'd3
    } grant_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_dma_rr_find.sv
`default_nettype none
// ============================================================================
// Module   : wb_dma_rr_find
// Brief    : Combinational rotating first-one finder over a channel mask.
// Revision : 1.0
// ============================================================================
module wb_dma_rr_find
    import wb_dma_grant_pkg::*;
#(
    parameter int N = CH_COUNT_MAX
)
(
    input  logic [N-1:0]          mask,
    input  logic [CH_IDX_W-1:0]   start,
    output logic                  hit,
    output logic [CH_IDX_W-1:0]   idx
);

    localparam int c_POS_W = CH_IDX_W + 1;

    logic [63:0]        w_mask_ext;
    logic [c_POS_W-1:0] w_pos;

    assign w_mask_ext = 64'(mask);

    // start is always < N, so one conditional subtract is enough to wrap
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, start} + c_POS_W'(k);
            if (w_pos >= c_POS_W'(N)) begin
                w_pos = w_pos - c_POS_W'(N);
            end
            if (!hit && w_mask_ext[w_pos]) begin
                hit = 1'b1;
                idx = w_pos[CH_IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_dma_ch_grant.sv
`default_nettype none
// ============================================================================
// Module   : wb_dma_ch_grant
// Brief    : Picks one channel at the encoder's priority and holds the grant
//            through the engine start/done handshake.
//            WB_DMA_CH_GRANT_RR_EN selects round-robin; otherwise fixed order.
// Revision : 1.0
// ============================================================================
module wb_dma_ch_grant
    import wb_dma_grant_pkg::*;
#(
    parameter int CH_COUNT = CH_COUNT_MAX,
    parameter int PRI_W    = PRI_W_DEF
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CH_COUNT-1:0]       valid,
    input  logic [CH_COUNT*PRI_W-1:0] pri,
    input  logic [PRI_W-1:0]          pri_out,
    input  logic                      de_start,
    input  logic                      de_done,
    output logic [CH_IDX_W-1:0]       ch_sel,
    output logic                      ch_sel_vld,
    output logic                      next_ch
);

    localparam logic [CH_IDX_W-1:0] c_LAST_CH = CH_IDX_W'(CH_COUNT - 1);

    grant_state_t          r_state;
    logic [CH_COUNT-1:0]   w_cand;
    logic [31:0]           w_valid_ext;
    logic [CH_IDX_W-1:0]   w_start;
    logic                  w_hit;
    logic [CH_IDX_W-1:0]   w_idx;

    genvar gi;
    generate
        for (gi = 0; gi < CH_COUNT; gi++) begin : g_cand
            assign w_cand[gi] = valid[gi] && (pri[gi*PRI_W +: PRI_W] == pri_out);
        end
    endgenerate

    // Zero-padded to 32 so a 5-bit ch_sel can index it directly
    assign w_valid_ext = 32'(valid);

`ifdef WB_DMA_CH_GRANT_RR_EN
    logic [CH_IDX_W-1:0] r_rr_ptr;
    assign w_start = (r_rr_ptr >= c_LAST_CH) ? '0 : r_rr_ptr + 1'b1;
`else
    assign w_start = '0;
`endif

    wb_dma_rr_find #(
        .N (CH_COUNT)
    ) u_find (
        .mask  (w_cand),
        .start (w_start),
        .hit   (w_hit),
        .idx   (w_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            ch_sel     <= '0;
            ch_sel_vld <= 1'b0;
            next_ch    <= 1'b0;
`ifdef WB_DMA_CH_GRANT_RR_EN
            r_rr_ptr   <= c_LAST_CH;
`endif
        end else begin
            next_ch <= 1'b0;
            case (r_state)
                IDLE: begin
                    ch_sel_vld <= 1'b0;
                    if (|valid) begin
                        r_state <= ARB;
                    end
                end
                ARB: begin
                    if (w_hit) begin
                        ch_sel     <= w_idx;
                        ch_sel_vld <= 1'b1;
                        r_state    <= GRANT;
                    end else begin
                        r_state    <= IDLE;
                    end
                end
                GRANT: begin
                    // de_start takes precedence over a same-cycle withdraw
                    if (de_start) begin
                        r_state <= BUSY;
                    end else if (!w_valid_ext[ch_sel]) begin
                        ch_sel_vld <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                BUSY: begin
                    if (de_done) begin
`ifdef WB_DMA_CH_GRANT_RR_EN
                        r_rr_ptr   <= ch_sel;
`endif
                        next_ch    <= 1'b1;
                        ch_sel_vld <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_dma_ch_grant.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_dma_ch_grant
// Brief    : Directed plus randomized check of the channel grant sequencer.
// Revision : 1.0
// ============================================================================
module tb_wb_dma_ch_grant;

    localparam int C  = 31;
    localparam int PW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [C-1:0]      valid;
    logic [C*PW-1:0]   pri;
    logic [PW-1:0]     pri_out;
    logic              de_start;
    logic              de_done;
    logic [4:0]        ch_sel;
    logic              ch_sel_vld;
    logic              next_ch;

    int checks = 0;
    int errors = 0;
    int m_rr   = C - 1;

    always #5 clk = ~clk;

    wb_dma_ch_grant #(
        .CH_COUNT (C),
        .PRI_W    (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .pri        (pri),
        .pri_out    (pri_out),
        .de_start   (de_start),
        .de_done    (de_done),
        .ch_sel     (ch_sel),
        .ch_sel_vld (ch_sel_vld),
        .next_ch    (next_ch)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: scan channels in service order, first matching candidate wins
    function automatic int model_pick(input logic [C-1:0] v, input logic [C*PW-1:0] p,
                                      input logic [PW-1:0] po);
        int start;
`ifdef WB_DMA_CH_GRANT_RR_EN
        start = (m_rr + 1) % C;
`else
        start = 0;
`endif
        for (int k = 0; k < C; k++) begin
            int i;
            i = (start + k) % C;
            if (v[i] && p[i*PW +: PW] == po) return i;
        end
        return -1;
    endfunction

    function automatic logic [C*PW-1:0] rand_pri();
        logic [C*PW-1:0] p;
        for (int i = 0; i < C; i++) p[i*PW +: PW] = PW'($urandom_range(0, 7));
        return p;
    endfunction

    // Full request/start/done transaction starting from IDLE with valid low
    task automatic grant_txn(input string tag, input logic [C-1:0] v, input logic [C*PW-1:0] p,
                             input logic [PW-1:0] po, input bit simul);
        int exp;
        logic [C-1:0] one;
        one = 1;
        @(negedge clk);
        check({tag, ":next_ch_pulse_end"}, 32'(next_ch), 0);
        valid = v; pri = p; pri_out = po;
        exp = model_pick(v, p, po);
        @(negedge clk);
        check({tag, ":arb_vld"}, 32'(ch_sel_vld), 0);
        @(negedge clk);
        check({tag, ":grant_vld"}, 32'(ch_sel_vld), 1);
        check({tag, ":grant_ch"}, 32'(ch_sel), 32'(exp));
        de_done = 1'b1;
        @(negedge clk);
        de_done = 1'b0;
        check({tag, ":done_ignored_in_grant"}, 32'(ch_sel_vld), 1);
        check({tag, ":no_pulse_in_grant"}, 32'(next_ch), 0);
        de_start = 1'b1;
        if (simul) valid = v & ~(one << exp);
        @(negedge clk);
        de_start = 1'b0;
        check({tag, ":busy_vld"}, 32'(ch_sel_vld), 1);
        valid = C'($urandom); pri = rand_pri(); pri_out = PW'($urandom_range(0, 7));
        @(negedge clk);
        check({tag, ":busy_frozen_ch"}, 32'(ch_sel), 32'(exp));
        valid = v; pri = p; pri_out = po;
        de_done = 1'b1;
        @(negedge clk);
        de_done = 1'b0;
        check({tag, ":next_ch"}, 32'(next_ch), 1);
        check({tag, ":vld_falls"}, 32'(ch_sel_vld), 0);
        m_rr = exp;
        valid = '0;
    endtask

    task automatic withdraw_txn(input string tag, input logic [C-1:0] v, input logic [C*PW-1:0] p,
                                input logic [PW-1:0] po);
        int exp;
        logic [C-1:0] one;
        one = 1;
        @(negedge clk);
        valid = v; pri = p; pri_out = po;
        exp = model_pick(v, p, po);
        @(negedge clk);
        @(negedge clk);
        check({tag, ":first_ch"}, 32'(ch_sel), 32'(exp));
        valid = v & ~(one << exp);
        @(negedge clk);
        check({tag, ":withdrawn_vld"}, 32'(ch_sel_vld), 0);
        valid = v;
        @(negedge clk);
        @(negedge clk);
        check({tag, ":regrant_vld"}, 32'(ch_sel_vld), 1);
        check({tag, ":regrant_same_ch"}, 32'(ch_sel), 32'(exp));
        valid = '0;
        @(negedge clk);
        check({tag, ":final_withdraw"}, 32'(ch_sel_vld), 0);
    endtask

    function automatic logic [C*PW-1:0] set_pri(input logic [C*PW-1:0] p, input int ch,
                                                input logic [PW-1:0] val);
        logic [C*PW-1:0] q;
        q = p;
        q[ch*PW +: PW] = val;
        return q;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [C-1:0]    v;
        logic [C*PW-1:0] p;
        logic [PW-1:0]   po;
        int              k;

        rst = 1'b0; valid = '0; pri = '0; pri_out = '0; de_start = 1'b0; de_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_vld", 32'(ch_sel_vld), 0);
        check("reset_ch", 32'(ch_sel), 0);
        check("reset_next", 32'(next_ch), 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'(ch_sel_vld), 0);

        // Single request on channel 4
        p = set_pri('0, 4, 3'd5);
        grant_txn("single", C'(1) << 4, p, 3'd5, 1'b0);

        // Asynchronous reset while busy on channel 7
        @(negedge clk);
        valid = C'(1) << 7; pri = set_pri('0, 7, 3'd1); pri_out = 3'd1;
        @(negedge clk);
        @(negedge clk);
        check("rstbusy_grant_ch", 32'(ch_sel), 7);
        de_start = 1'b1;
        @(negedge clk);
        de_start = 1'b0;
        check("rstbusy_busy_vld", 32'(ch_sel_vld), 1);
        #2 rst = 1'b0;
        #1;
        check("rstbusy_vld_drop", 32'(ch_sel_vld), 0);
        check("rstbusy_ch_zero", 32'(ch_sel), 0);
        check("rstbusy_next_zero", 32'(next_ch), 0);
        valid = '0;
        m_rr = C - 1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rstbusy_stays_idle", 32'(ch_sel_vld), 0);
        end

        // Equal-priority fairness across 2, 9, 30 and wrap
        p = set_pri(set_pri(set_pri('0, 2, 3'd3), 9, 3'd3), 30, 3'd3);
        v = (C'(1) << 2) | (C'(1) << 9) | (C'(1) << 30);
        repeat (4) grant_txn("rr", v, p, 3'd3, 1'b0);

        // Priority filter: only channel 6 matches pri_out
        p = set_pri(set_pri('0, 1, 3'd2), 6, 3'd7);
        grant_txn("prifilter", (C'(1) << 1) | (C'(1) << 6), p, 3'd7, 1'b0);

        // Withdraw keeps the pointer where it was
        p = set_pri(set_pri('0, 3, 3'd4), 5, 3'd4);
        withdraw_txn("withdraw", (C'(1) << 3) | (C'(1) << 5), p, 3'd4);

        // Same-cycle withdraw and start: start wins
        p = set_pri(set_pri('0, 2, 3'd1), 9, 3'd1);
        grant_txn("simul", (C'(1) << 2) | (C'(1) << 9), p, 3'd1, 1'b1);
        grant_txn("eqpri", (C'(1) << 2) | (C'(1) << 9), p, 3'd1, 1'b0);

        // Randomized traffic with a guaranteed candidate
        for (int n = 0; n < 25; n++) begin
            v = C'($urandom);
            if (v == '0) v[0] = 1'b1;
            p = rand_pri();
            do k = $urandom_range(0, C - 1); while (!v[k]);
            po = p[k*PW +: PW];
            grant_txn("random", v, p, po, bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_dma_ch_grant.md
# wb_dma_ch_grant

Channel grant sequencer that consumes the highest-unserviced priority produced by `wb_dma_ch_pri_enc` and turns it into one granted channel for the DMA engine. Among valid channels whose priority equals `pri_out`, it picks one by round-robin and holds the grant through an engine start/done handshake. It then advances its pointer so that equal-priority channels are served fairly. It sits between the priority encoder and the DMA engine's channel select path.

## Interface
- `CH_COUNT`, 31: number of channels, 1..31.
- `PRI_W`, 3: priority field width.
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `valid` in CH_COUNT: per-channel request-valid bits.
- `pri` in CH_COUNT*PRI_W: packed channel priorities; channel i occupies `[i*PRI_W +: PRI_W]`.
- `pri_out` in PRI_W: highest unserviced priority from the encoder; combinational input.
- `de_start` in 1: engine accepted the current grant.
- `de_done` in 1: engine finished the granted transfer.
- `ch_sel` out 5: granted channel index.
- `ch_sel_vld` out 1: `ch_sel` is valid.
- `next_ch` out 1: one-cycle pulse when a granted transfer completes.

## Operation
- The block has four states: IDLE, ARB, GRANT and BUSY.
- Candidate set: channels i with `valid[i]` set and `pri[i] == pri_out`.
- **IDLE**:
  - `ch_sel_vld` = 0.
  - If `valid` is nonzero, go to ARB.
- **ARB**:
  - Search the candidate set starting at `rr_ptr+1`, wrapping modulo CH_COUNT. The first hit is loaded into `ch_sel`, then go to GRANT.
  - If there is no candidate (valid dropped, or `pri_out` matches nothing), return to IDLE. `ch_sel` is unchanged.
- **GRANT**:
  - `ch_sel_vld` = 1.
  - If `de_start` is set, go to BUSY.
  - If `valid[ch_sel]` is 0 and `de_start` is 0, withdraw: go to IDLE with `rr_ptr` unchanged.
  - If both happen in the same cycle, `de_start` wins.
- **BUSY**:
  - `ch_sel_vld` = 1; `ch_sel` is frozen.
  - On `de_done`: `rr_ptr` ← `ch_sel`, `next_ch` pulses for 1 cycle, go to IDLE.
  - Changes on `valid`, `pri` and `pri_out` are ignored in this state.
- `de_done` is ignored outside BUSY. `de_start` is ignored outside GRANT.
- `ch_sel` index math is 5-bit. Wrap-around: after index CH_COUNT-1 the search continues at 0.

## Timing
- Reset values:
  - state = IDLE
  - `ch_sel` = 0
  - `ch_sel_vld` = 0
  - `next_ch` = 0
  - `rr_ptr` = CH_COUNT-1, so channel 0 is searched first.
- Reset asserted mid-grant or mid-busy: all outputs drop immediately (asynchronous). The pending transfer is forgotten.
- Grant latency: `valid` sampled high in IDLE at edge N → ARB after N → `ch_sel`/`ch_sel_vld` registered at edge N+1. That is 2 cycles from the `valid` rise.
- `next_ch` is registered: it is high in the cycle after the edge that samples `de_done`. `ch_sel_vld` falls on that same edge.
- Earliest re-grant after `de_done` is 2 cycles later (IDLE→ARB→GRANT).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `WB_DMA_CH_GRANT_RR_EN` defined: round-robin search from `rr_ptr+1` as above.
- Undefined:
  - Fixed priority: the ARB search always starts at index 0, so the lowest index wins among equals.
  - `rr_ptr` is not implemented.
  - `next_ch` still pulses.

## Structure
- Shared package `wb_dma_grant_pkg`:
  - state enum (IDLE, ARB, GRANT, BUSY)
  - `CH_IDX_W` = 5
  - `CH_COUNT_MAX` = 31
  - `PRI_W_DEF` = 3
- Sub-module `wb_dma_rr_find`: combinational rotating first-one finder. Inputs are the candidate mask and start index; outputs are `hit` and index. With RR disabled its start index is tied to 0.

## Test plan
- **Reset**: assert `rst`=0 mid-BUSY with `ch_sel`=7 → `ch_sel_vld`=0, `ch_sel`=0 and `next_ch`=0 immediately. After release with `valid`=0 the block stays in IDLE.
- **Single request**: `valid`=bit 4, `pri[4]`=5, `pri_out`=5.
  - `ch_sel`=4 and `ch_sel_vld`=1 exactly 2 cycles after the `valid` rise.
  - `de_start` then `de_done` → `next_ch` is a 1-cycle pulse and `ch_sel_vld` falls on the same edge.
- **Round-robin**: channels 2, 9 and 30 all at `pri`=3 with `pri_out`=3, held valid, three complete handshakes → grants in order 2, 9, 30, then 2 again (wrap).
- **Priority filter**: channel 1 at pri 2 and channel 6 at pri 7, `pri_out`=7 → grant to 6 only.
- **Withdraw**: in GRANT with `ch_sel`=3, drop `valid[3]` with `de_start`=0 → IDLE; the next grant among {3, 5} with both valid is 3 again (pointer unchanged).
- **Simultaneous / ignored events**:
  - Drop `valid[ch_sel]` in the same cycle `de_start`=1 → BUSY.
  - `de_done` asserted in GRANT is ignored.
  - With `WB_DMA_CH_GRANT_RR_EN` undefined, channels 2 and 9 at equal priority are granted 2 every time.
